seq_divider: RTL



---
 rtl/seq_divider.sv | 117 +++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Purpose : restoring divider, unsigned DIVIDEND_W / DIVISOR_W -> quotient + remainder, one quotient bit per clock.
// Latency : result valid DIVIDEND_W cycles after the accept edge (1 cycle for a zero divisor); one operation in flight.
// Backpr. : in_ready only in IDLE; result held stable in DONE until out_ready; no same-cycle consume+accept bypass.
//
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   in_valid/in_ready      - operand handshake (dividend, divisor)
//   out_valid/out_ready    - result handshake (quotient, remainder, div_by_zero)
module seq_divider #(
    parameter int DIVIDEND_W = 34,
    parameter int DIVISOR_W  = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

    state_t                  state;
    logic [DIVIDEND_W-1:0]   dvd;     // dividend bits shift out MSB-first, quotient bits shift in at LSB
    logic [DIVISOR_W-1:0]    dvs;
    logic [DIVISOR_W-1:0]    p;       // partial remainder; always < divisor between steps, so its top bit is never needed
    logic [CNT_W-1:0]        cnt;

    logic [DIVISOR_W:0]      p_shift; // full DIVISOR_W+1 bit working value of the step
    logic                    take;
    logic [DIVISOR_W-1:0]    p_next;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        p_shift = {p, dvd[DIVIDEND_W-1]};
        take    = (p_shift >= {1'b0, dvs});
        p_next  = take ? DIVISOR_W'(p_shift - {1'b0, dvs}) : p_shift[DIVISOR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            p           <= '0;
            dvd         <= '0;
            dvs         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd      <= dividend;
                        dvs      <= divisor;
                        cnt      <= '0;
                        p        <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end

                BUSY: begin
                    // A zero divisor still spends one cycle here so its result
                    // appears one edge after acceptance.
                    if (dvs == '0) begin
                        quotient    <= '1;
                        remainder   <= '0;
                        div_by_zero <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        p   <= p_next;
                        dvd <= {dvd[DIVIDEND_W-2:0], take};
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_ITER) begin
                            quotient    <= {dvd[DIVIDEND_W-2:0], take};
                            remainder   <= p_next;
                            div_by_zero <= 1'b0;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
